// File: rtl/objective.sv
// objective: training-side terminator of a neuron layer's res/err interface.
// Results are paired with buffered target labels. The scaled signed error
// (target - result) << RATE is returned on the err channel, saturated to Q8.8.
// Optional feature macro OBJECTIVE_STATS_EN adds cnt_dat, a saturating count
// of error handshakes that carried a nonzero error.
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for a result; en=0 drops it, en=1 needs a target
//   HOLD  | error registered on err_dat, waiting for err_rdy
module objective #(
    parameter int DEPTH = 4,
    parameter int RATE  = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        res_stb,
    input  logic [7:0]  res_dat,
    output logic        res_rdy,
    input  logic        tgt_stb,
    input  logic [7:0]  tgt_dat,
    output logic        tgt_rdy,
    output logic        err_stb,
    output logic [15:0] err_dat,
    input  logic        err_rdy
`ifdef OBJECTIVE_STATS_EN
    ,
    output logic [15:0] cnt_dat
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               res_fire;
    logic signed [8:0]  diff;
    logic signed [17:0] diff_ext;
    logic signed [17:0] scaled;
    logic [15:0]        err_sat;

    // Handshake qualifiers; both ready outputs are forced low while in reset.
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign tgt_rdy  = rst & ~full;
    assign res_rdy  = rst & (state == IDLE) & (~en | ~empty);
    assign push     = tgt_stb & tgt_rdy;
    assign res_fire = res_stb & res_rdy;
    // A result consumed in inference mode never touches the target FIFO.
    assign pop      = res_fire & en;

    // Error arithmetic: 9-bit signed difference, sign-extended to 18 bits so the
    // largest shift (255 << 8) cannot overflow before saturation.
    assign diff     = $signed({1'b0, mem[rd_ptr]}) - $signed({1'b0, res_dat});
    assign diff_ext = {{9{diff[8]}}, diff};
    assign scaled   = diff_ext <<< RATE;

    // Clamp the scaled error into the signed 16-bit Q8.8 range.
    always_comb begin
        err_sat = scaled[15:0];
        if (scaled > 18'sd32767) begin
            err_sat = 16'h7FFF;
        end else if (scaled < -18'sd32768) begin
            err_sat = 16'h8000;
        end
    end

    // Target FIFO storage; contents need no reset since count guards them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tgt_dat;
        end
    end

    // Target FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Result/error sequencing with registered err_stb and err_dat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            err_stb <= 1'b0;
            err_dat <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        err_dat <= err_sat;
                        err_stb <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    // err_dat is deliberately left holding the last error.
                    if (err_rdy) begin
                        err_stb <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    err_stb <= 1'b0;
                end
            endcase
        end
    end

`ifdef OBJECTIVE_STATS_EN
    // Saturating count of delivered errors that were nonzero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_dat <= 16'h0000;
        end else if (err_stb && err_rdy && (err_dat != 16'h0000) && (cnt_dat != 16'hFFFF)) begin
            cnt_dat <= cnt_dat + 16'd1;
        end
    end
`endif

endmodule
